layer3_window_reader: RTL and testbench

//  Read-side sequencer for the layer-3 result SRAM. It walks every KxK stride-1 window of the
//  IMG_W x IMG_W layer-3 feature map and fetches each window's pixels through the memory read port
//  (read_row/col addr + read signal). Each assembled window goes to the layer-4 engine over a

---
 rtl/layer3_window_reader.sv | 94 +++++++++
 tb/tb_layer3_window_reader.sv | 124 ++++++++++++
 2 files changed

// File: rtl/layer3_window_reader.sv
// layer3_window_reader: walks every KxK stride-1 window of the layer-3 map and streams it out.
// Define LAYER3_COLUMN_REUSE_EN to reuse K-1 buffered columns between horizontally adjacent windows.
module layer3_window_reader #(
  parameter int DATA_W = 128,
  parameter int IMG_W = 14,
  parameter int K = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  l3_rd_en,
  output logic [15:0]           l3_rd_row,
  output logic [15:0]           l3_rd_col,
  input  logic [DATA_W-1:0]     l3_rdata,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [K*K*DATA_W-1:0] win_data,
  output logic [15:0]           win_row,
  output logic [15:0]           win_col,
  output logic                  win_last
);
  typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;
`ifdef LAYER3_COLUMN_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif
  localparam logic [15:0] KM1 = 16'(K - 1);
  localparam logic [15:0] LAST = 16'(IMG_W - K);
  state_t state, next_state;
  logic [15:0] fi, fj;
  logic [K*K-1:0][DATA_W-1:0] wb;
  logic last_win, fetch_end, hs, reuse_next;
  assign last_win = win_row == LAST && win_col == LAST;
  assign fetch_end = state == FETCH && fi == KM1 && fj == KM1;
  assign hs = state == EMIT && win_ready;
  assign reuse_next = REUSE && win_col != LAST;
  assign win_data = wb;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  next_state = start ? FETCH : IDLE;
      FETCH: next_state = fetch_end ? EMIT : FETCH;
      EMIT:  next_state = hs ? (last_win ? DONE : FETCH) : EMIT;
      DONE:  next_state = IDLE;
    endcase
    l3_rd_en = state == FETCH;
    l3_rd_row = l3_rd_en ? win_row + fi : '0;
    l3_rd_col = l3_rd_en ? win_col + fj : '0;
    win_valid = state == EMIT;
    win_last = win_valid && last_win;
    busy = state == FETCH || state == EMIT;
    done = state == DONE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fi <= '0;
      fj <= '0;
      win_row <= '0;
      win_col <= '0;
      wb <= '0;
    end else begin
      if (state == IDLE && start) begin
        fi <= '0;
        fj <= '0;
        win_row <= '0;
        win_col <= '0;
      end
      if (state == FETCH) begin
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            if (fi == 16'(i) && fj == 16'(j)) wb[i*K+j] <= l3_rdata;
        // in reuse mode only the rightmost column is refetched for windows with col > 0
        fj <= fj == KM1 ? ((REUSE && win_col != 0) ? KM1 : '0) : fj + 16'd1;
        fi <= fj == KM1 ? fi + 16'd1 : fi;
      end
      if (hs && !last_win) begin
        win_col <= win_col == LAST ? '0 : win_col + 16'd1;
        win_row <= win_col == LAST ? win_row + 16'd1 : win_row;
        fi <= '0;
        fj <= reuse_next ? KM1 : '0;
        if (reuse_next)
          for (int i = 0; i < K; i++)
            for (int j = 0; j < K - 1; j++)
              wb[i*K+j] <= wb[i*K+j+1];
      end
    end
  end
endmodule

// File: tb/tb_layer3_window_reader.sv
// tb_layer3_window_reader: directed checks of window order, contents, timing, stall and reset.
`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); end end
module tb_layer3_window_reader;
  localparam int DW = 128, N = 14, K = 3;
`ifdef LAYER3_COLUMN_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif
  localparam int BASE = REUSE ? 12*10 + 132*4 : 144*10;
  logic clk = 0, rst = 0, start = 0, win_ready = 1;
  logic busy, done, l3_rd_en, win_valid, win_last;
  logic [15:0] l3_rd_row, l3_rd_col, win_row, win_col;
  logic [DW-1:0] l3_rdata = '0;
  logic [K*K*DW-1:0] win_data;
  int checks = 0, errors = 0;
  layer3_window_reader #(.DATA_W(DW), .IMG_W(N), .K(K)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .l3_rd_en(l3_rd_en), .l3_rd_row(l3_rd_row), .l3_rd_col(l3_rd_col), .l3_rdata(l3_rdata),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_row(win_row), .win_col(win_col), .win_last(win_last));
  always #5 clk = ~clk;
  always @(negedge clk) l3_rdata <= l3_rd_en ? {112'd0, l3_rd_row[7:0], l3_rd_col[7:0]} : '0;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic reset_checks();
    checks += 3;
    if ({busy, done, l3_rd_en, win_valid, win_last} !== 5'd0) begin
      errors++;
      $error("FAIL reset_ctl observed=%0b", {busy, done, l3_rd_en, win_valid, win_last});
    end
    if ({l3_rd_row, l3_rd_col, win_row, win_col} !== 64'd0) begin
      errors++;
      $error("FAIL reset_addr observed=%0h", {l3_rd_row, l3_rd_col, win_row, win_col});
    end
    if (win_data !== '0) begin
      errors++;
      $error("FAIL reset_data observed=%0h", win_data);
    end
  endtask
  task automatic run_frame(input bit stall, input bit spam);
    int er, ec, hs_n, done_n, busy_n, stall_n, last_hs, exp_gap;
    logic [K*K*DW+32:0] snap;
    logic [DW-1:0] ew;
    er = 0; ec = 0; hs_n = 0; done_n = 0; busy_n = 0; stall_n = 0; last_hs = -1; snap = '0;
    start = 1;
    step();
    start = 0;
    for (int cyc = 0; cyc < 4000 && done_n == 0; cyc++) begin
      start = spam && (cyc % 50 == 3);
      busy_n += int'(busy);
      if (done) begin
        done_n++;
        `CHK("busy_at_done", busy, 1'b0)
      end
      if (cyc == 9) begin
        `CHK("first_valid", win_valid, 1'b1)
        `CHK("first_slot4", win_data[4*DW +: DW], 128'h0101)
      end
      win_ready = 1;
      if (win_valid && stall && er == 0 && ec == 1 && stall_n < 7) begin
        win_ready = 0;
        if (stall_n == 0) snap = {win_data, win_row, win_col, win_last};
        else `CHK("frozen", ({win_data, win_row, win_col, win_last} == snap), 1'b1)
        `CHK("no_read_in_stall", l3_rd_en, 1'b0)
        stall_n++;
      end else if (win_valid) begin
        `CHK("win_pos", ({win_row, win_col, win_last}), ({16'(er), 16'(ec), er == N-K && ec == N-K}))
        for (int s = 0; s < K*K; s++) begin
          ew = {112'd0, 8'(er + s / K), 8'(ec + s % K)};
          `CHK("slot", win_data[s*DW +: DW], ew)
        end
        exp_gap = ((REUSE && ec != 0) ? K + 1 : K*K + 1) + ((stall && er == 0 && ec == 1) ? 7 : 0);
        `CHK("win_gap", cyc - last_hs, exp_gap)
        last_hs = cyc;
        hs_n++;
        if (ec == N-K) begin ec = 0; er++; end
        else ec++;
      end
      step();
    end
    start = 0;
    `CHK("handshakes", hs_n, 144)
    `CHK("done_pulses", done_n, 1)
    `CHK("busy_cycles", busy_n, BASE + (stall ? 7 : 0))
    `CHK("idle_after", ({busy, done}), 2'b00)
  endtask
  initial begin
    int n;
    step();
    step();
    reset_checks();
    rst = 1;
    step();
    run_frame(1'b0, 1'b0);
    step();
    run_frame(1'b1, 1'b0);
    step();
    start = 1;
    step();
    start = 0;
    n = 0;
    while (!(l3_rd_en && win_row == 16'd5 && win_col == 16'd3) && n < 3000) begin
      step();
      n++;
    end
    checks++;
    if ({l3_rd_en, win_row, win_col} !== {1'b1, 16'd5, 16'd3}) begin
      errors++;
      $error("FAIL reach_5_3 timeout after %0d cycles observed=%0h", n, {l3_rd_en, win_row, win_col});
    end
    rst = 0;
    #1;
    reset_checks();
    step();
    rst = 1;
    step();
    run_frame(1'b0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
